// File: rtl/gpio_int_pkg.sv
// Shared types and default sizing for the GPIO interrupt aggregator.
package gpio_int_pkg;

   localparam int N_SRC_DEF = 8;
   localparam int ID_W_DEF  = $clog2(N_SRC_DEF);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

endpackage

// File: rtl/gpio_int_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set bit and whether any bit is set.
module gpio_int_prio_enc #(
   parameter int N    = 8,
   parameter int ID_W = 3
) (
   input  logic [N-1:0]    i_vec,
   output logic [ID_W-1:0] o_id,
   output logic            o_any
);

   always_comb begin
      o_id  = '0;
      o_any = |i_vec;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_vec[k]) o_id = ID_W'(k);
      end
   end

endmodule

// File: rtl/gpio_int_aggr.sv
// GPIO interrupt aggregator: edge capture, pending/overflow tracking, fixed-priority presentation with post-ack holdoff.
// Optional ack-timeout watchdog enabled by defining GPIO_INT_AGGR_TIMEOUT_EN.
module gpio_int_aggr
   import gpio_int_pkg::*;
#(
   parameter int N_SRC     = N_SRC_DEF,
   parameter int HOLDOFF_W = 8,
   localparam int ID_W     = $clog2(N_SRC)
) (
   input  logic                 clk_apb,
   input  logic                 rst_apb,
   input  logic [N_SRC-1:0]     int_raw,
   input  logic [N_SRC-1:0]     int_mask,
   input  logic [HOLDOFF_W-1:0] holdoff_cycles,
   input  logic                 irq_ack,
   input  logic                 ovf_clr,
   output logic                 irq_valid,
   output logic [ID_W-1:0]      irq_id,
   output logic [N_SRC-1:0]     pend,
   output logic                 overflow,
   output logic                 ack_timeout
);

   logic [N_SRC-1:0]     r_raw_q;
   logic [N_SRC-1:0]     r_edge;
   logic [N_SRC-1:0]     r_pend;
   logic                 r_ovf;
   state_t               r_state;
   logic [ID_W-1:0]      r_id;
   logic [HOLDOFF_W-1:0] r_cnt;

   logic                 w_ack;
   logic                 w_timeout;
   logic [N_SRC-1:0]     w_clr;
   logic                 w_ovf_evt;
   logic [ID_W-1:0]      w_id;
   logic                 w_any;

   assign w_ack     = (r_state == ST_ASSERT) && irq_ack;
   assign w_clr     = w_ack ? ({{(N_SRC-1){1'b0}}, 1'b1} << r_id) : '0;
   // A bit being acked in the same cycle as its new edge is not an overflow; the edge re-arms it.
   assign w_ovf_evt = |(r_edge & r_pend & ~w_clr);

   gpio_int_prio_enc #(
      .N    (N_SRC),
      .ID_W (ID_W)
   ) u_prio_enc (
      .i_vec (r_pend & ~int_mask),
      .o_id  (w_id),
      .o_any (w_any)
   );

   always_ff @(posedge clk_apb) begin
      if (rst_apb) begin
         r_raw_q <= '0;
         r_edge  <= '0;
         r_pend  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_raw_q <= int_raw;
         r_edge  <= int_raw & ~r_raw_q;
         r_pend  <= (r_pend & ~w_clr) | r_edge;
         if (w_ovf_evt)    r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk_apb) begin
      if (rst_apb) begin
         r_state <= ST_IDLE;
         r_id    <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_ASSERT;
                  r_id    <= w_id;
               end
            end
            ST_ASSERT: begin
               if (w_ack) begin
                  if (holdoff_cycles == '0) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt   <= holdoff_cycles;
                     r_state <= ST_HOLDOFF;
                  end
               end else if (w_timeout) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_HOLDOFF: begin
               // Leaving as the count steps down to 1 keeps irq_valid low for exactly holdoff_cycles cycles.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt <= HOLDOFF_W'(2)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef GPIO_INT_AGGR_TIMEOUT_EN
   logic [15:0] r_to_cnt;
   logic        r_to_flag;

   assign w_timeout = (r_state == ST_ASSERT) && !irq_ack && (r_to_cnt == 16'hFFFF);

   always_ff @(posedge clk_apb) begin
      if (rst_apb) begin
         r_to_cnt  <= '0;
         r_to_flag <= 1'b0;
      end else begin
         if ((r_state != ST_ASSERT) || w_ack) r_to_cnt <= '0;
         else                                 r_to_cnt <= r_to_cnt + 16'd1;
         if (w_timeout)    r_to_flag <= 1'b1;
         else if (ovf_clr) r_to_flag <= 1'b0;
      end
   end

   assign ack_timeout = r_to_flag;
`else
   assign w_timeout   = 1'b0;
   assign ack_timeout = 1'b0;
`endif

   assign irq_valid = (r_state == ST_ASSERT);
   assign irq_id    = r_id;
   assign pend      = r_pend;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_gpio_int_aggr.sv
// Directed bench for gpio_int_aggr; the timeout section is built only with GPIO_INT_AGGR_TIMEOUT_EN.
module tb_gpio_int_aggr;

   logic       clk_apb = 1'b0;
   logic       rst_apb;
   logic [7:0] int_raw;
   logic [7:0] int_mask;
   logic [7:0] holdoff_cycles;
   logic       irq_ack;
   logic       ovf_clr;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic [7:0] pend;
   logic       overflow;
   logic       ack_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_int_aggr dut (
      .clk_apb        (clk_apb),
      .rst_apb        (rst_apb),
      .int_raw        (int_raw),
      .int_mask       (int_mask),
      .holdoff_cycles (holdoff_cycles),
      .irq_ack        (irq_ack),
      .ovf_clr        (ovf_clr),
      .irq_valid      (irq_valid),
      .irq_id         (irq_id),
      .pend           (pend),
      .overflow       (overflow),
      .ack_timeout    (ack_timeout)
   );

   always #5 clk_apb = ~clk_apb;

   task automatic tick();
      @(posedge clk_apb);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_apb = 1'b1; int_raw = '0; int_mask = '0; holdoff_cycles = '0;
      irq_ack = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      chk("rst_valid", 32'(irq_valid), 32'd0);
      chk("rst_id", 32'(irq_id), 32'd0);
      chk("rst_pend", 32'(pend), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_to", 32'(ack_timeout), 32'd0);
      rst_apb = 1'b0;
      tick();

      // single source, 3-cycle latency
      int_raw = 8'h04;
      tick(); chk("s_lat1_valid", 32'(irq_valid), 32'd0);
      tick(); chk("s_lat2_pend", 32'(pend), 32'h04);
      chk("s_lat2_valid", 32'(irq_valid), 32'd0);
      tick(); chk("s_valid", 32'(irq_valid), 32'd1);
      chk("s_id", 32'(irq_id), 32'd2);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("s_ack_pend", 32'(pend), 32'h00);
      chk("s_ack_valid", 32'(irq_valid), 32'd0);

      // priority between two simultaneous edges
      int_raw = 8'h00; tick();
      int_raw = 8'h90; tick(); tick(); tick();
      chk("p_valid", 32'(irq_valid), 32'd1);
      chk("p_id4", 32'(irq_id), 32'd4);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("p_pend", 32'(pend), 32'h80);
      chk("p_gap", 32'(irq_valid), 32'd0);
      tick();
      chk("p_id7", 32'(irq_id), 32'd7);
      chk("p_valid7", 32'(irq_valid), 32'd1);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("p_done", 32'(pend), 32'h00);

      // masking holds presentation; stray ack is ignored
      int_raw = 8'h00; int_mask = 8'h01; tick();
      int_raw = 8'h01; tick(); tick(); tick(); tick();
      chk("m_pend", 32'(pend), 32'h01);
      chk("m_valid", 32'(irq_valid), 32'd0);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("m_stray_ack", 32'(pend), 32'h01);
      int_mask = 8'h00; tick();
      chk("m_valid_un", 32'(irq_valid), 32'd1);
      chk("m_id", 32'(irq_id), 32'd0);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("m_done", 32'(pend), 32'h00);

      // holdoff of 5 with a second source waiting
      holdoff_cycles = 8'd5;
      int_raw = 8'h00; tick();
      int_raw = 8'h06; tick(); tick(); tick();
      chk("h_id1", 32'(irq_id), 32'd1);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("h_low%0d", i), 32'(irq_valid), 32'd0);
         tick();
      end
      chk("h_valid", 32'(irq_valid), 32'd1);
      chk("h_id2", 32'(irq_id), 32'd2);
      holdoff_cycles = 8'd0;
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("h_done", 32'(pend), 32'h00);

      // overflow on bit 3, clear, then edge racing the ack
      int_raw = 8'h00; tick();
      int_raw = 8'h08; tick();
      int_raw = 8'h00; tick();
      int_raw = 8'h08; tick(); tick();
      chk("o_ovf", 32'(overflow), 32'd1);
      chk("o_id3", 32'(irq_id), 32'd3);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("o_clr", 32'(overflow), 32'd0);
      int_raw = 8'h00; tick();
      int_raw = 8'h08; tick();
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      chk("r_pend", 32'(pend), 32'h08);
      chk("r_ovf", 32'(overflow), 32'd0);
      tick();
      chk("r_repres", 32'(irq_valid), 32'd1);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;

      // reset while presenting
      int_raw = 8'h00; tick();
      int_raw = 8'h20; tick(); tick(); tick();
      chk("x_id5", 32'(irq_id), 32'd5);
      rst_apb = 1'b1; tick(); rst_apb = 1'b0;
      chk("x_valid", 32'(irq_valid), 32'd0);
      chk("x_id", 32'(irq_id), 32'd0);
      chk("x_pend", 32'(pend), 32'h00);
      chk("x_ovf", 32'(overflow), 32'd0);
      chk("x_to", 32'(ack_timeout), 32'd0);

`ifdef GPIO_INT_AGGR_TIMEOUT_EN
      int_raw = 8'h00; tick(); tick();
      int_raw = 8'h40; tick(); tick(); tick();
      chk("t_valid", 32'(irq_valid), 32'd1);
      for (int i = 0; i < 65535; i++) tick();
      chk("t_before", 32'(ack_timeout), 32'd0);
      tick();
      chk("t_flag", 32'(ack_timeout), 32'd1);
      chk("t_idle", 32'(irq_valid), 32'd0);
      tick();
      chk("t_repres", 32'(irq_valid), 32'd1);
      chk("t_id6", 32'(irq_id), 32'd6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_int_aggr.md
GPIO_INT_AGGR -- requirements
Module: gpio_int_aggr

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (matches the GPIO int_raw width).
REQ-002 SHALL have parameter HOLDOFF_W, default 8, width of the post-ack holdoff counter.
REQ-003 SHALL have port clk_apb, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_apb, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port int_raw, input, N_SRC, sticky per-source status from the GPIO block, synchronous to clk_apb.
REQ-006 SHALL have port int_mask, input, N_SRC, per-source mask; 1 = masked.
REQ-007 SHALL have port holdoff_cycles, input, HOLDOFF_W, idle cycles enforced after each ack.
REQ-008 SHALL have port irq_ack, input, 1, CPU acknowledge of the current irq_id.
REQ-009 SHALL have port ovf_clr, input, 1, clears overflow.
REQ-010 SHALL have port irq_valid, output, 1, an interrupt is presented.
REQ-011 SHALL have port irq_id, output, $clog2(N_SRC), index of the presented source.
REQ-012 SHALL have port pend, output, N_SRC, pending vector, unmasked view.
REQ-013 SHALL have port overflow, output, 1, sticky flag: an edge arrived on an already-pending source.
REQ-014 SHALL have port ack_timeout, output, 1, sticky ack-timeout flag (see REQ-031).

Function
REQ-015 SHALL register int_raw each cycle and detect rising edges as int_raw & ~int_raw_q.
REQ-016 SHALL set pend[k] the cycle after a rising edge on int_raw[k], independent of int_mask.
REQ-017 SHALL set overflow when a rising edge hits a source whose pend bit is already 1.
REQ-018 SHALL run FSM IDLE -> ASSERT -> HOLDOFF -> IDLE.
REQ-019 In IDLE, SHALL go to ASSERT when (pend & ~int_mask) != 0.
REQ-020 On entering ASSERT, SHALL latch irq_id as the lowest-index set bit of pend & ~int_mask (fixed priority).
REQ-021 SHALL drive irq_valid = 1 only in ASSERT.
REQ-022 SHALL hold irq_id constant throughout ASSERT even if int_mask or pend change.
REQ-023 On irq_ack in ASSERT, SHALL clear pend[irq_id], load the holdoff counter with holdoff_cycles, and enter HOLDOFF.
REQ-024 If holdoff_cycles = 0, SHALL go directly from ASSERT to IDLE.
REQ-025 In HOLDOFF, SHALL decrement the counter each cycle and go to IDLE when it reaches 1.
REQ-026 SHALL ignore irq_ack outside ASSERT.
REQ-027 When an edge and an ack-clear target the same bit in one cycle, SHALL leave pend set (set wins) without setting overflow.
REQ-028 Latency from an int_raw edge to irq_valid SHALL be 3 cycles: edge register, pend, ASSERT.
REQ-029 SHALL clear overflow on ovf_clr; a simultaneous overflow event wins.

Reset
REQ-030 On rst_apb, SHALL force FSM = IDLE, pend = 0, int_raw_q = 0, counters = 0, irq_valid = 0, irq_id = 0, overflow = 0, ack_timeout = 0, with effect at the next clk_apb edge and regardless of the current state.

Configuration
REQ-031 With GPIO_INT_AGGR_TIMEOUT_EN defined, SHALL run a 16-bit counter in ASSERT.
- At 16'hFFFF without an ack: sets sticky ack_timeout, returns to IDLE, keeps pend (re-arbitrates).
- ovf_clr also clears ack_timeout.
REQ-032 Without GPIO_INT_AGGR_TIMEOUT_EN, SHALL tie ack_timeout to 0 and wait in ASSERT indefinitely.

Structure
REQ-033 SHALL take the FSM state enum typedef and the default N_SRC/ID width constants from shared package gpio_int_pkg.
REQ-034 SHALL instantiate one sub-module, gpio_int_prio_enc: lowest-index priority encoder producing id plus an any-set flag.

Verification
REQ-035 Single source: int_raw 0x00 -> 0x04, mask 0, holdoff 0 -> irq_valid 3 cycles later with irq_id = 2; ack -> pend = 0, irq_valid low the next cycle.
REQ-036 Priority: int_raw 0x00 -> 0x90 in one cycle -> irq_id = 4; ack -> next presented irq_id = 7.
REQ-037 Mask: mask = 0x01, edge on bit 0 -> pend = 0x01, no irq_valid; mask -> 0x00 -> irq_valid with irq_id = 0.
REQ-038 Holdoff: holdoff_cycles = 5, two pending sources -> after the first ack, irq_valid stays low for exactly 5 cycles.
REQ-039 Overflow and race: second edge on pending bit 3 -> overflow = 1; edge coincident with ack of bit 3 -> pend[3] stays 1, overflow unchanged.
REQ-040 Reset mid-ASSERT: rst_apb high one cycle -> all outputs 0 next cycle; with TIMEOUT_EN, no ack for 65535 cycles -> ack_timeout = 1 and re-presentation.
